// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, also used by the display/overlay blocks.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W = 10;

  // A divide-by-1 still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic in_span(input logic [CNT_W-1:0] val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a registered one-clk pixel enable.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;

  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // Registering the compare on the next value keeps p_tick aligned with div_cnt == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      p_tick  <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster counters with registered sync/blanking decode and end-of-frame strobe.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_end
);

  localparam int LINE_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(LINE_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(FRAME_TOTAL - 1);

  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] h_next;
  logic [9:0] v_next;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .p_tick(p_tick)
  );

  always_comb begin
    h_next = h;
    v_next = v;
    if (p_tick) begin
      if (h == H_LAST) begin
        h_next = '0;
        v_next = (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h_next = h + 10'd1;
      end
    end
  end

  // Decoding from h_next/v_next lets the registered flags land in the same clk as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      h        <= h_next;
      v        <= v_next;
      hsync    <= !in_span(h_next, H_DISPLAY + H_FRONT, H_DISPLAY + H_FRONT + H_SYNC);
      vsync    <= !in_span(v_next, V_DISPLAY + V_FRONT, V_DISPLAY + V_FRONT + V_SYNC);
      video_on <= in_span(h_next, 0, H_DISPLAY) && in_span(v_next, 0, V_DISPLAY);
    end
  end

  assign pixel_x   = h;
  assign pixel_y   = v;
  assign frame_end = p_tick && (h == H_LAST) && (v == V_LAST);

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz).
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch.
- H_SYNC, 96, hsync pulse width.
- H_BACK, 48, horizontal back porch.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch.
- V_SYNC, 2, vsync pulse width.
- V_BACK, 33, vertical back porch.

REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- p_tick, out, 1, one-clk pixel enable.
- pixel_x, out, 10, current horizontal count.
- pixel_y, out, 10, current vertical count.
- video_on, out, 1, visible-area flag.
- hsync, out, 1, horizontal sync, active-low.
- vsync, out, 1, vertical sync, active-low.
- frame_end, out, 1, one-clk pulse on the last pixel of a frame.

Function
REQ-003 A divider counter (width clog2(CLK_DIV)) SHALL count 0..CLK_DIV-1 and wrap, every clk.
- p_tick SHALL be high for exactly one clk when the divider equals CLK_DIV-1.
- Resulting period: 4 clks at the default CLK_DIV.

REQ-004 The horizontal counter h SHALL advance only in clks where p_tick=1.
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
- h wraps from H_TOTAL-1 (799) to 0.

REQ-005 The vertical counter v SHALL advance only when p_tick=1 and h=H_TOTAL-1.
- V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- v wraps from V_TOTAL-1 (524) to 0 in the same clk that h wraps.

REQ-006 pixel_x SHALL equal h, and pixel_y SHALL equal v.
- Both are held constant for the CLK_DIV clks between ticks.

REQ-007 hsync SHALL be 0 iff H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (656..751).

REQ-008 vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC (490..491).

REQ-009 video_on SHALL be 1 iff h < H_DISPLAY and v < V_DISPLAY.

REQ-010 hsync, vsync and video_on SHALL be flip-flop outputs, decoded from the next-state counter values.
- They are therefore always coherent with pixel_x/pixel_y in the same clk.
- They have zero latency relative to the counters and are glitch-free.

REQ-011 frame_end SHALL be 1 for exactly one clk: the clk where p_tick=1, h=799 and v=524.

REQ-012 Counter arithmetic SHALL be 10-bit unsigned.
- The wrap compare SHALL be equality with TOTAL-1; no counter value >= TOTAL is ever reachable.

REQ-013 Downstream sprite and overlay blocks SHALL be able to consume pixel_x/pixel_y directly.
- Downstream blocks SHALL gate their output with video_on.

Reset
REQ-014 While rst_n=0, all state SHALL hold these values:
- divider=0, h=0, v=0.
- p_tick=0, frame_end=0.
- hsync=1, vsync=1, video_on=1 (coherent with h=v=0).

REQ-015 Assertion of rst_n mid-frame SHALL take effect immediately (asynchronous), regardless of the clk phase.

REQ-016 After rst_n deasserts, the first p_tick SHALL occur on the CLK_DIV-th rising clk edge.
- h becomes 1 on that edge.

Structure
REQ-017 The timing constants and derived H_TOTAL/V_TOTAL SHALL live in a shared package, vga_timing_pkg.
- This package is also used by the display/overlay blocks.

REQ-018 The divider SHALL be a single sub-module, pixel_tick_gen (clk, rst_n -> p_tick).
- The counters and sync decode SHALL stay in vga_sync.

REQ-019 The block SHALL contain no combinational paths from inputs to outputs.
- It SHALL contain no latches.

Verification
REQ-020 Tick check: release reset, count 40 clks -> p_tick is high at clk 4, 8, ..., 40 only; pixel_x = 10 at clk 40.

REQ-021 Line wrap: run to h=799, v=0, then one tick -> h=0, v=1; hsync low for exactly 96 ticks, starting at h=656.

REQ-022 Frame wrap: run 800*525 ticks -> frame_end pulses once, coincident with h=799 and v=524; next tick gives h=0, v=0.
- vsync low for exactly 1600 ticks (v=490..491).

REQ-023 Visible area: over one frame, count ticks with video_on=1 -> exactly 307200.
- video_on=0 at (640,0) and at (0,480).

REQ-024 Reset mid-operation: assert rst_n=0 at h=700, v=300 between ticks -> same-cycle outputs h=0, v=0, hsync=1, vsync=1, video_on=1.
- Deassert -> counting restarts per REQ-016.

REQ-025 Coherence: on every clk, check the registered hsync, vsync and video_on against a reference decode of pixel_x/pixel_y -> zero mismatches over 2 full frames.
